// File: rtl/core_ex_agu_lsu_req_if.sv
// Handshake bundles for the AGU request stage: the upstream side from issue
// and the downstream side toward the LSU, including the misalign report.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_LSU_INST_WIDTH
`define CORE_LSU_INST_WIDTH 4
`endif

interface core_ex_agu_req_if #(
    parameter int XLEN = `CORE_XLEN,
    parameter int LIW  = `CORE_LSU_INST_WIDTH
);
    logic            i_valid;
    logic            o_ready;
    logic [LIW-1:0]  i_lsu_inst_bus;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd;
    logic            i_flush;

    modport master (output i_valid, i_lsu_inst_bus, i_rs1, i_imm, i_rs2, i_rd, i_flush,
                    input  o_ready);
    modport slave  (input  i_valid, i_lsu_inst_bus, i_rs1, i_imm, i_rs2, i_rd, i_flush,
                    output o_ready);
endinterface

interface core_ex_agu_lsu_if #(
    parameter int XLEN = `CORE_XLEN,
    parameter int LIW  = `CORE_LSU_INST_WIDTH
);
    logic            o_valid;
    logic            i_lsu_ready;
    logic [LIW-1:0]  o_lsu_inst_bus;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_write_data;
    logic [4:0]      o_rd;
    logic            o_misalign_valid;
    logic [XLEN-1:0] o_misalign_addr;
    logic            o_misalign_store;

    modport master (output o_valid, o_lsu_inst_bus, o_mem_addr, o_write_data, o_rd,
                           o_misalign_valid, o_misalign_addr, o_misalign_store,
                    input  i_lsu_ready);
    modport slave  (input  o_valid, o_lsu_inst_bus, o_mem_addr, o_write_data, o_rd,
                           o_misalign_valid, o_misalign_addr, o_misalign_store,
                    output i_lsu_ready);
endinterface

// File: rtl/core_ex_agu_lsu_req.sv
// AGU request stage: forms rs1+imm, screens misaligned accesses, and buffers
// aligned loads/stores in a two-entry FIFO in front of the LSU.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_LSU_INST_WIDTH
`define CORE_LSU_INST_WIDTH 4
`endif
`ifndef CORE_LSU_INST_LOAD
`define CORE_LSU_INST_LOAD 0
`endif
`ifndef CORE_LSU_INST_STORE
`define CORE_LSU_INST_STORE 1
`endif
`ifndef CORE_LSU_INST_SIZE
`define CORE_LSU_INST_SIZE 3:2
`endif

module core_ex_agu_lsu_req #(
    parameter int XLEN  = `CORE_XLEN,
    parameter int LIW   = `CORE_LSU_INST_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    core_ex_agu_req_if.slave  req,
    core_ex_agu_lsu_if.master lsu
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    typedef struct packed {
        logic [LIW-1:0]  inst;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [1:0]      count_q, count_d;
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic            mis_vld_q, mis_vld_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic            mis_st_q, mis_st_d;

    logic [XLEN-1:0] ea;
    logic [1:0]      size;
    logic            is_ld, is_st, is_mem, misal;
    logic            ready, accept, push, pop;
    entry_t          head;

    assign ea     = req.i_rs1 + req.i_imm;
    assign size   = req.i_lsu_inst_bus[`CORE_LSU_INST_SIZE];
    assign is_ld  = req.i_lsu_inst_bus[`CORE_LSU_INST_LOAD];
    assign is_st  = req.i_lsu_inst_bus[`CORE_LSU_INST_STORE];
    assign is_mem = is_ld | is_st;
    // Byte never faults; size[1] covers word (and the unused 11 encoding).
    assign misal  = ((size == 2'b01) & ea[0]) | (size[1] & (|ea[1:0]));

    // Ready is a function of occupancy only, never of a same-cycle pop.
    assign ready  = ~rst & (count_q < DEPTH_C) & ~req.i_flush;
    assign accept = req.i_valid & ready;
    assign push   = accept & is_mem & ~misal;
    assign pop    = (count_q != 2'd0) & lsu.i_lsu_ready;

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mis_vld_d  = accept & is_mem & misal;
        mis_addr_d = mis_addr_q;
        mis_st_d   = mis_st_q;
        if (req.i_flush) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            count_d = count_q + 2'(push) - 2'(pop);
            wptr_d  = wptr_q ^ push;
            rptr_d  = rptr_q ^ pop;
        end
        if (mis_vld_d) begin
            mis_addr_d = ea;
            mis_st_d   = is_st;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            mis_vld_q  <= 1'b0;
            mis_addr_q <= '0;
            mis_st_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mis_vld_q  <= mis_vld_d;
            mis_addr_q <= mis_addr_d;
            mis_st_q   <= mis_st_d;
        end
    end

    // Payload storage needs no reset: it is only visible behind o_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= '{inst: req.i_lsu_inst_bus, addr: ea,
                               wdata: req.i_rs2, rd: req.i_rd};
        end
    end

    assign head    = mem_q[rptr_q];
    assign req.o_ready = ready;

    assign lsu.o_valid        = (count_q != 2'd0);
    assign lsu.o_lsu_inst_bus = lsu.o_valid ? head.inst  : '0;
    assign lsu.o_mem_addr     = lsu.o_valid ? head.addr  : '0;
    assign lsu.o_write_data   = lsu.o_valid ? head.wdata : '0;
    assign lsu.o_rd           = lsu.o_valid ? head.rd    : '0;

    // A flush arriving while the pulse is up cancels it.
    assign lsu.o_misalign_valid = mis_vld_q & ~req.i_flush;
    assign lsu.o_misalign_addr  = mis_addr_q;
    assign lsu.o_misalign_store = mis_st_q;

endmodule
